microwave_cook_controller: RTL
==============================

// Module: microwave_cook_controller
// PURPOSE
//  Parametrised single-module oven controller: keypad BCD time entry, MM:SS countdown,
//  power-level duty cycling of the magnetron, pause/resume on door or stop, done flag.
//  Provides wider minute fields, power levels and pause/resume over the fixed 3-digit
//  controller. Drives BCD digits to the existing BCD_decoder; segment decode is external.
// PARAMETERS
//  MIN_DIGITS   1    number of BCD minute digits (max time = 10^MIN_DIGITS-1 : 99 raw)
//  CLK_PER_SEC  100  clock cycles per countdown second; must be a multiple of PWR_LEVELS
//  PWR_LEVELS   10   number of power levels; level P gives duty P/PWR_LEVELS
//  BEEP_SECS    3    beep length in seconds (used only with DONE_BEEP_EN)
// PORTS
//  clock        in   1              rising-edge system clock
//  reset        in   1              synchronous, active-high reset
//  start_       in   1              start/resume button, active low
//  stop_        in   1              stop/pause button, active low
//  clear_       in   1              clear button, active low
//  door_closed  in   1              1 = door closed
//  keypad       in   10             one-hot digit keys, keypad[k] = digit k, active high
//  power_key    in   1              power-level step button, active high
//  mag_on       out  1              magnetron enable
//  done         out  1              cook complete, held until acknowledged
//  beep         out  1              done beeper (0 unless DONE_BEEP_EN)
//  state        out  2              0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
//  sec_ones     out  4              BCD seconds ones
//  sec_tens     out  4              BCD seconds tens
//  mins         out  4*MIN_DIGITS   BCD minutes, digit 0 in [3:0]
//  power        out  $clog2(PWR_LEVELS+1)  current power level 1..PWR_LEVELS
// BEHAVIOUR
//  - Reset: state IDLE, all digits 0, power=PWR_LEVELS, mag_on/done/beep 0, counters 0.
//  - All buttons edge-detected, one registered stage: one action per press, acted on
//    the cycle after the press edge is sampled. keypad with !=1 bit set is ignored.
//  - Priority per cycle: reset > clear_ > door open > stop_ > start_ > second tick > keys.
//  - IDLE: digit k shifts in: sec_ones<=k, sec_tens<=sec_ones, mins[0]<=sec_tens,
//    mins[i]<=mins[i-1]; top minute digit discarded. Entered digits 0-9 anywhere (0:90 legal).
//    power_key: power decrements, 1 wraps to PWR_LEVELS.
//    start_ with door closed: time nonzero -> COOK; time zero -> load 0:30, COOK.
//    start_ with door open: ignored.
//  - COOK: prescaler counts 0..CLK_PER_SEC-1; at wrap time decrements by 1 s:
//    sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows mins; minute digits borrow 0->9.
//    Decrement reaching 0:00 -> DONE next cycle, done=1. door open or stop_ -> PAUSE,
//    prescaler held. keypad/power_key ignored.
//  - PAUSE: start_ with door closed -> COOK, prescaler resumes from held value.
//    stop_ or clear_ -> IDLE, time 0, power=PWR_LEVELS.
//  - DONE: any start_/stop_/clear_/keypad press or door opening -> IDLE, done=0, time 0.
//  - clear_ in any state: IDLE, time 0, power=PWR_LEVELS, done=0.
//  - mag_on = (state==COOK) & (prescaler < power*(CLK_PER_SEC/PWR_LEVELS)) & door_closed;
//    the door_closed term is combinational: mag_on never high with door open.
//  - reset mid-COOK: all outputs to reset values on the next edge; no residual mag_on.
// CONFIGURATION
//  DONE_BEEP_EN defined: on entry to DONE, beep=1 for BEEP_SECS*CLK_PER_SEC cycles or until
//    leaving DONE, whichever first; done stays high independently.
//  DONE_BEEP_EN undefined: beep tied 0, no beep counter synthesised.
// TESTING (CLK_PER_SEC=10, PWR_LEVELS=10, MIN_DIGITS=1)
//  1 keys 1,3,0, door closed, start_ -> COOK at 1:30; after 10 clocks 1:29; after 90 total
//    ticks 0:00, state DONE, done=1, mag_on=0.
//  2 power_key x3 (->7), key 5, start_ -> mag_on high 7 of every 10 clocks, 5 s -> DONE.
//  3 COOK 0:20, door open at 0:15 mid-second -> mag_on 0 same cycle, PAUSE; close, start_ ->
//    COOK, next tick after remaining prescaler cycles, reaches DONE with 20 s total on-time.
//  4 IDLE 0:00, start_ with door open -> stays IDLE; door closed start_ -> COOK at 0:30.
//  5 COOK 1:00 -> next second 0:59; PAUSE then stop_ -> IDLE, 0:00, power 10.
//  6 DONE_BEEP_EN: DONE entry -> beep high 30 clocks then 0, done still 1; keypress -> IDLE.

Source files
------------

// File: rtl/microwave_cook_controller_if.sv
// Front-panel / display bundle between the oven controller and its surroundings.
// The master side drives buttons, keypad and door; the slave side (controller) drives the outputs.
interface microwave_cook_controller_if #(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned PWR_LEVELS = 10
);
  localparam int unsigned MW = 4 * MIN_DIGITS;
  localparam int unsigned PW = $clog2(PWR_LEVELS + 1);

  logic          start_;
  logic          stop_;
  logic          clear_;
  logic          door_closed;
  logic [9:0]    keypad;
  logic          power_key;
  logic          mag_on;
  logic          done;
  logic          beep;
  logic [1:0]    state;
  logic [3:0]    sec_ones;
  logic [3:0]    sec_tens;
  logic [MW-1:0] mins;
  logic [PW-1:0] power;

  modport master (
    output start_, stop_, clear_, door_closed, keypad, power_key,
    input  mag_on, done, beep, state, sec_ones, sec_tens, mins, power
  );

  modport slave (
    input  start_, stop_, clear_, door_closed, keypad, power_key,
    output mag_on, done, beep, state, sec_ones, sec_tens, mins, power
  );
endinterface

// File: rtl/microwave_cook_controller.sv
// Oven controller: keypad BCD time entry, MM:SS countdown, duty-cycled magnetron, pause/resume.
// Define DONE_BEEP_EN to build the timed done beeper; otherwise beep is tied low.
module microwave_cook_controller #(
  parameter int unsigned MIN_DIGITS  = 1,
  parameter int unsigned CLK_PER_SEC = 100,
  parameter int unsigned PWR_LEVELS  = 10,
  parameter int unsigned BEEP_SECS   = 3
) (
  input logic                        clock,
  input logic                        reset,
  microwave_cook_controller_if.slave bus
);
  localparam int unsigned MW   = 4 * MIN_DIGITS;
  localparam int unsigned PW   = $clog2(PWR_LEVELS + 1);
  localparam int unsigned SW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned STEP = CLK_PER_SEC / PWR_LEVELS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] PWR_MAX   = PW'(PWR_LEVELS);
  localparam logic [SW-1:0] PRESC_MAX = SW'(CLK_PER_SEC - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic [MW-1:0] mins_q, mins_d;
  logic [PW-1:0] power_q, power_d;
  logic [SW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic [3:0]    btn_s_q, btn_p_q;
  logic [9:0]    kp_s_q, kp_p_q;

  logic          start_ev, stop_ev, clear_ev, pwr_ev, key_ev, kp_any_ev;
  logic [3:0]    key_digit_c;
  logic [3:0]    dec_ones_c, dec_tens_c;
  logic [MW-1:0] dec_mins_c;
  logic          dec_borrow_c, dec_zero_c, time_zero_c;

  // Press edges: sample stage then previous stage; act on the cycle after the press is sampled
  assign start_ev  = btn_s_q[0] & ~btn_p_q[0];
  assign stop_ev   = btn_s_q[1] & ~btn_p_q[1];
  assign clear_ev  = btn_s_q[2] & ~btn_p_q[2];
  assign pwr_ev    = btn_s_q[3] & ~btn_p_q[3];
  assign key_ev    = $onehot(kp_s_q) && (kp_p_q == 10'd0);
  assign kp_any_ev = (kp_s_q != 10'd0) && (kp_p_q == 10'd0);

  assign time_zero_c = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == '0);

  always_comb begin
    key_digit_c = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (kp_s_q[k]) key_digit_c = 4'(k);
    end
  end

  // One-second BCD decrement with borrow chain through seconds and minute digits
  always_comb begin
    dec_ones_c   = ones_q - 4'd1;
    dec_tens_c   = tens_q;
    dec_mins_c   = mins_q;
    dec_borrow_c = 1'b0;
    if (ones_q == 4'd0) begin
      dec_ones_c = 4'd9;
      if (tens_q == 4'd0) begin
        dec_tens_c   = 4'd5;
        dec_borrow_c = 1'b1;
      end else begin
        dec_tens_c = tens_q - 4'd1;
      end
    end
    for (int i = 0; i < int'(MIN_DIGITS); i++) begin
      if (dec_borrow_c) begin
        if (mins_q[4*i +: 4] == 4'd0) begin
          dec_mins_c[4*i +: 4] = 4'd9;
        end else begin
          dec_mins_c[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
          dec_borrow_c         = 1'b0;
        end
      end
    end
    dec_zero_c = (dec_ones_c == 4'd0) && (dec_tens_c == 4'd0) && (dec_mins_c == '0);
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    power_d = power_q;
    presc_d = presc_q;
    done_d  = done_q;
    if (clear_ev) begin
      state_d = S_IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      mins_d  = '0;
      power_d = PWR_MAX;
      presc_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stop_ev) begin
            if (start_ev) begin
              if (bus.door_closed) begin
                state_d = S_COOK;
                presc_d = '0;
                if (time_zero_c) tens_d = 4'd3;
              end
            end else if (key_ev) begin
              ones_d = key_digit_c;
              tens_d = ones_q;
              mins_d = MW'({mins_q, tens_q});
            end else if (pwr_ev) begin
              power_d = (power_q == PW'(1)) ? PWR_MAX : power_q - 1'b1;
            end
          end
        end
        S_COOK: begin
          // Prescaler freezes while the door is open so on-time is never lost
          if (!bus.door_closed || stop_ev) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            ones_d  = dec_ones_c;
            tens_d  = dec_tens_c;
            mins_d  = dec_mins_c;
            if (dec_zero_c) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop_ev) begin
            state_d = S_IDLE;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            mins_d  = '0;
            power_d = PWR_MAX;
            presc_d = '0;
          end else if (start_ev && bus.door_closed) begin
            state_d = S_COOK;
          end
        end
        default: begin
          if (!bus.door_closed || stop_ev || start_ev || kp_any_ev) begin
            state_d = S_IDLE;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            mins_d  = '0;
            presc_d = '0;
            done_d  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      mins_q  <= '0;
      power_q <= PWR_MAX;
      presc_q <= '0;
      done_q  <= 1'b0;
      btn_s_q <= 4'd0;
      btn_p_q <= 4'd0;
      kp_s_q  <= 10'd0;
      kp_p_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      mins_q  <= mins_d;
      power_q <= power_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      btn_s_q <= {bus.power_key, ~bus.clear_, ~bus.stop_, ~bus.start_};
      btn_p_q <= btn_s_q;
      kp_s_q  <= bus.keypad;
      kp_p_q  <= kp_s_q;
    end
  end

`ifdef DONE_BEEP_EN
  localparam int unsigned BEEP_CYC = BEEP_SECS * CLK_PER_SEC;
  localparam int unsigned BW       = $clog2(BEEP_CYC + 1);

  logic          beep_q, beep_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  // Beep starts on DONE entry and stops after BEEP_CYC cycles or on leaving DONE
  always_comb begin
    beep_d = 1'b0;
    bcnt_d = '0;
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        beep_d = 1'b1;
      end else if (beep_q && (bcnt_q != BW'(BEEP_CYC - 1))) begin
        beep_d = 1'b1;
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beep_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign bus.beep = beep_q;
`else
  assign bus.beep = 1'b0;
`endif

  // Door term is combinational so the magnetron drops the instant the door opens
  assign bus.mag_on   = (state_q == S_COOK) && (32'(presc_q) < 32'(power_q) * STEP) && bus.door_closed;
  assign bus.done     = done_q;
  assign bus.state    = state_q;
  assign bus.sec_ones = ones_q;
  assign bus.sec_tens = tens_q;
  assign bus.mins     = mins_q;
  assign bus.power    = power_q;
endmodule
